// File: rtl/dm_arbiter_pkg.sv
// Shared encodings for the data-memory arbiter: access sizes, arbiter states
// and port indices, plus the alignment fault rule used by the byte-enable logic.
package dm_arbiter_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_BURST = 1'b1
    } arbState_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DMA = 1'b1;

    // Halves must be 2-byte aligned, words 4-byte aligned; size 11 is reserved.
    function automatic logic isFault(input logic [1:0] size, input logic [1:0] addrLow);
        logic fault;
        case (size)
            SIZE_BYTE: fault = 1'b0;
            SIZE_HALF: fault = addrLow[0];
            SIZE_WORD: fault = (addrLow != 2'b00);
            default:   fault = 1'b1;
        endcase
        return fault;
    endfunction

endpackage

// File: rtl/dm_arbiter_be_gen.sv
// Turns the granted request's size, low address bits and right-aligned store
// data into dm byte enables, lane-replicated write data and a fault flag.
module dm_arbiter_be_gen
    import dm_arbiter_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_addrLow,
    input  logic [31:0] i_wdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wd,
    output logic        o_fault
);

    always_comb begin
        o_be    = 4'b0000;
        o_wd    = i_wdata;
        o_fault = isFault(i_size, i_addrLow);
        case (i_size)
            SIZE_BYTE: begin
                o_be = 4'b0001 << i_addrLow;
                o_wd = {4{i_wdata[7:0]}};
            end
            SIZE_HALF: begin
                o_be = i_addrLow[1] ? 4'b1100 : 4'b0011;
                o_wd = {2{i_wdata[15:0]}};
            end
            SIZE_WORD: begin
                o_be = 4'b1111;
                o_wd = i_wdata;
            end
            default: begin
                o_be = 4'b0000;
                o_wd = i_wdata;
            end
        endcase
        // A faulting access still gets its grant but must never touch memory.
        if (o_fault) begin
            o_be = 4'b0000;
        end
    end

endmodule

// File: rtl/dm_arbiter.sv
// Shares the single-port data memory between the CPU M-stage (port 0) and the
// DMA engine (port 1) with round-robin arbitration and a bounded DMA burst lock.
module dm_arbiter
    import dm_arbiter_pkg::*;
#(
    parameter int MAX_BURST = 8,
    parameter int CNT_W     = 8
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        i_req0,
    input  logic        i_req1,
    input  logic        i_we0,
    input  logic        i_we1,
    input  logic [1:0]  i_size0,
    input  logic [1:0]  i_size1,
    input  logic [31:0] i_addr0,
    input  logic [31:0] i_addr1,
    input  logic [31:0] i_wdata0,
    input  logic [31:0] i_wdata1,
    input  logic [31:0] i_pc0,
    input  logic        i_lock1,
    output logic        o_gnt0,
    output logic        o_gnt1,
    output logic        o_err0,
    output logic        o_err1,
    output logic [31:0] o_rdata,
    output logic        o_dm_WE,
    output logic [3:0]  o_dm_BE,
    output logic [31:0] o_dm_Addr,
    output logic [31:0] o_dm_WD,
    output logic [31:0] o_dm_PC,
    input  logic [31:0] i_dm_RD
);

    arbState_t          r_state;
    logic [CNT_W-1:0]   r_count;
    logic               r_last;

    logic               w_dmaLocked;
    logic               w_gnt0;
    logic               w_gnt1;
    logic               w_granted;
    logic               w_we;
    logic [1:0]         w_size;
    logic [31:0]        w_addr;
    logic [31:0]        w_wdata;
    logic [3:0]         w_be;
    logic [31:0]        w_wd;
    logic               w_fault;

    assign w_dmaLocked = (r_state == ARB_BURST) && i_req1 && i_lock1;

    // Reset blanks both grants, which in turn blanks every memory-side output.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (!Reset) begin
            if (w_dmaLocked) begin
                w_gnt1 = 1'b1;
            end else if (i_req0 && i_req1) begin
                if (r_last == PORT_DMA) begin
                    w_gnt0 = 1'b1;
                end else begin
                    w_gnt1 = 1'b1;
                end
            end else if (i_req0) begin
                w_gnt0 = 1'b1;
            end else if (i_req1) begin
                w_gnt1 = 1'b1;
            end
        end
    end

    assign w_granted = w_gnt0 | w_gnt1;
    assign w_we      = w_gnt1 ? i_we1    : i_we0;
    assign w_size    = w_gnt1 ? i_size1  : i_size0;
    assign w_addr    = w_gnt1 ? i_addr1  : i_addr0;
    assign w_wdata   = w_gnt1 ? i_wdata1 : i_wdata0;

    dm_arbiter_be_gen u_be_gen (
        .i_size    (w_size),
        .i_addrLow (w_addr[1:0]),
        .i_wdata   (w_wdata),
        .o_be      (w_be),
        .o_wd      (w_wd),
        .o_fault   (w_fault)
    );

    assign o_gnt0    = w_gnt0;
    assign o_gnt1    = w_gnt1;
    assign o_err0    = w_gnt0 & w_fault;
    assign o_err1    = w_gnt1 & w_fault;
    assign o_dm_WE   = w_granted & w_we & ~w_fault;
    assign o_dm_BE   = w_granted ? w_be : 4'b0000;
    assign o_dm_Addr = w_granted ? {w_addr[31:2], 2'b00} : 32'h0;
    assign o_dm_WD   = w_granted ? w_wd : 32'h0;
    assign o_dm_PC   = w_gnt0 ? i_pc0 : 32'h0;
    assign o_rdata   = w_granted ? i_dm_RD : 32'h0;

    // Leaving a burst always follows a DMA grant, so last already points at
    // the DMA and a waiting CPU takes the next contested cycle.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= ARB_IDLE;
            r_count <= '0;
            r_last  <= PORT_DMA;
        end else begin
            if (w_gnt0) begin
                r_last <= PORT_CPU;
            end else if (w_gnt1) begin
                r_last <= PORT_DMA;
            end
            case (r_state)
                ARB_IDLE: begin
                    if (w_gnt1 && i_lock1) begin
                        r_state <= ARB_BURST;
                        r_count <= CNT_W'(1);
                    end
                end
                ARB_BURST: begin
                    if (!w_dmaLocked || (r_count == CNT_W'(MAX_BURST - 1))) begin
                        r_state <= ARB_IDLE;
                        r_count <= '0;
                    end else begin
                        r_count <= r_count + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= ARB_IDLE;
                    r_count <= '0;
                end
            endcase
        end
    end

endmodule
